// File: rtl/riscv_multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences IF/ID/EX/MEM/WB,
// drives datapath enables and alu_op, and counts retired instructions.
module riscv_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_I    = 3'b001;
    localparam logic [2:0] ALU_S    = 3'b010;
    localparam logic [2:0] ALU_B    = 3'b011;
    localparam logic [2:0] ALU_U    = 3'b100;
    localparam logic [2:0] ALU_J    = 3'b101;
    localparam logic [2:0] ALU_ADD  = 3'b110;
    localparam logic [2:0] ALU_JALR = 3'b111;

    state_t cur_state, next_state;
    logic   retire;

    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: is_known = 1'b1;
            default:                              is_known = 1'b0;
        endcase
    endfunction

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= S_IF;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state = cur_state;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 3'b000;
        pc_source  = 2'd0;

        case (cur_state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'd1;
                    alu_op     = ALU_ADD;
                    next_state = S_ID;
                end
            end

            S_ID: begin
                // Speculative branch/JAL target: ALUOut <= old_pc + imm.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                if (opcode == OP_ECALL) begin
                    next_state = S_HALT;
                    retire     = 1'b1;
                end else if (is_known(opcode)) begin
                    next_state = S_EX;
                end else begin
                    next_state = S_IF;
                    retire     = 1'b1;
                end
            end

            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd0;
                        alu_op     = ALU_R;
                        next_state = S_WB;
                    end
                    OP_I: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_I;
                        next_state = S_WB;
                    end
                    OP_LUI: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_U;
                        next_state = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a  = 2'd1;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_ADD;
                        next_state = S_WB;
                    end
                    OP_LOAD: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_ADD;
                        next_state = S_MEM;
                    end
                    OP_STORE: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_S;
                        next_state = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd0;
                        alu_op     = ALU_B;
                        pc_source  = 2'd1;
                        pc_write   = bcond;
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                    OP_JAL: begin
                        alu_op     = ALU_J;
                        pc_write   = 1'b1;
                        pc_source  = 2'd1;
                        reg_write  = 1'b1;
                        mem_to_reg = 2'd2;
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_a  = 2'd2;
                        alu_src_b  = 2'd2;
                        alu_op     = ALU_JALR;
                        pc_write   = 1'b1;
                        pc_source  = 2'd0;
                        reg_write  = 1'b1;
                        mem_to_reg = 2'd2;
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                    default: begin
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                // Request held every cycle until memory signals completion.
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) mem_read  = 1'b1;
                else                   mem_write = 1'b1;
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        next_state = S_WB;
                    end else begin
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                next_state = S_IF;
                retire     = 1'b1;
            end

            S_HALT: begin
                next_state = S_HALT;
            end

            default: begin
                next_state = S_IF;
            end
        endcase

        // Reset wins over everything so an aborted instruction never writes.
        if (!reset_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Scoreboard bench for riscv_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle control outputs.
module tb_riscv_multicycle_control;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [6:0]       opcode;
    logic             bcond;
    logic             mem_ready;
    logic             pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]       mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic [2:0]       alu_op, state;
    logic             halted;
    logic [CNT_W-1:0] retired;

    riscv_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .bcond(bcond),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .halted(halted), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // mode 0: check everything; 1: enables only; 2: enables + state/retired/halted
    typedef struct {
        int          mode;
        logic [2:0]  st;
        logic        pcw, irw, iod, mr, mw, rw;
        logic [1:0]  m2r, sa, sb, ps;
        logic [2:0]  op;
        logic        halt;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] m_ret = 0;

    logic [6:0] known_ops[9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
                                 OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc++;
            check("pc_write",  32'(pc_write),  32'(mon_e.pcw));
            check("ir_write",  32'(ir_write),  32'(mon_e.irw));
            check("mem_read",  32'(mem_read),  32'(mon_e.mr));
            check("mem_write", 32'(mem_write), 32'(mon_e.mw));
            check("reg_write", 32'(reg_write), 32'(mon_e.rw));
            if (mon_e.mode != 1) begin
                check("state",   32'(state),   32'(mon_e.st));
                check("retired", retired,      mon_e.ret);
                check("halted",  32'(halted),  32'(mon_e.halt));
            end
            if (mon_e.mode == 0) begin
                check("i_or_d",     32'(i_or_d),     32'(mon_e.iod));
                check("mem_to_reg", 32'(mem_to_reg), 32'(mon_e.m2r));
                check("alu_src_a",  32'(alu_src_a),  32'(mon_e.sa));
                check("alu_src_b",  32'(alu_src_b),  32'(mon_e.sb));
                check("alu_op",     32'(alu_op),     32'(mon_e.op));
                check("pc_source",  32'(pc_source),  32'(mon_e.ps));
            end
        end
    end

    function automatic logic is_known(input logic [6:0] op);
        foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e.mode = 0; e.st = st;
        e.pcw = 0; e.irw = 0; e.iod = 0; e.mr = 0; e.mw = 0; e.rw = 0;
        e.m2r = 0; e.sa = 0; e.sb = 0; e.ps = 0; e.op = 0;
        e.halt = (st == 3'd5);
        e.ret  = m_ret;
        return e;
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic rn, input logic [6:0] op, input logic bc,
                        input logic mr, input exp_t e);
        reset_n   = rn;
        opcode    = op;
        bcond     = bc;
        mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // First cycle sees whatever state the reset interrupts; later ones see IF.
    task automatic reset_cycles(input int n, input logic [6:0] op);
        exp_t e;
        e = base(3'd0);
        e.mode = 1;
        step(1'b0, op, rbit(), 1'b1, e);
        m_ret = 0;
        for (int i = 1; i < n; i++) begin
            e = base(3'd0);
            e.mode = 2;
            step(1'b0, op, rbit(), 1'b1, e);
        end
    endtask

    task automatic halt_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = base(3'd5);
            step(1'b1, rnd7(), rbit(), 1'(i % 2), e);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int if_wait, input int mem_wait,
                             input logic bc, input bit rst_in_mem);
        exp_t e;
        for (int i = 0; i < if_wait; i++) begin
            e = base(3'd0); e.mr = 1;
            step(1'b1, rnd7(), rbit(), 1'b0, e);
        end
        e = base(3'd0); e.mr = 1; e.irw = 1; e.pcw = 1; e.sb = 1; e.op = 3'b110;
        step(1'b1, rnd7(), rbit(), 1'b1, e);
        e = base(3'd1); e.sa = 1; e.sb = 2; e.op = 3'b110;
        step(1'b1, op, rbit(), rbit(), e);
        if (op == OP_ECALL || !is_known(op)) begin
            m_ret++;
            return;
        end

        e = base(3'd2);
        case (op)
            OP_R:      begin e.sa = 2; e.sb = 0; e.op = 3'b000; end
            OP_I:      begin e.sa = 2; e.sb = 2; e.op = 3'b001; end
            OP_LUI:    begin e.sa = 2; e.sb = 2; e.op = 3'b100; end
            OP_AUIPC:  begin e.sa = 1; e.sb = 2; e.op = 3'b110; end
            OP_LOAD:   begin e.sa = 2; e.sb = 2; e.op = 3'b110; end
            OP_STORE:  begin e.sa = 2; e.sb = 2; e.op = 3'b010; end
            OP_BRANCH: begin e.sa = 2; e.sb = 0; e.op = 3'b011; e.ps = 1; e.pcw = bc; end
            OP_JAL:    begin e.op = 3'b101; e.pcw = 1; e.ps = 1; e.rw = 1; e.m2r = 2; end
            default:   begin e.sa = 2; e.sb = 2; e.op = 3'b111; e.pcw = 1; e.ps = 0;
                             e.rw = 1; e.m2r = 2; end
        endcase
        step(1'b1, op, (op == OP_BRANCH) ? bc : rbit(), rbit(), e);

        if (op == OP_BRANCH || op == OP_JAL || op == OP_JALR) begin
            m_ret++;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            for (int i = 0; i < mem_wait; i++) begin
                e = base(3'd3); e.iod = 1;
                if (op == OP_LOAD) e.mr = 1; else e.mw = 1;
                step(1'b1, op, rbit(), 1'b0, e);
            end
            if (rst_in_mem) begin
                reset_cycles(2, op);
                return;
            end
            e = base(3'd3); e.iod = 1;
            if (op == OP_LOAD) e.mr = 1; else e.mw = 1;
            step(1'b1, op, rbit(), 1'b1, e);
            if (op == OP_LOAD) begin
                e = base(3'd4); e.rw = 1; e.m2r = 1;
                step(1'b1, op, rbit(), rbit(), e);
            end
            m_ret++;
        end else begin
            e = base(3'd4); e.rw = 1; e.m2r = 0;
            step(1'b1, op, rbit(), rbit(), e);
            m_ret++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        int         k;
        reset_n = 1'b0; opcode = 7'd0; bcond = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        reset_cycles(2, OP_R);
        run_instr(OP_R,      0, 0, 1'b0, 1'b0);
        run_instr(OP_LOAD,   0, 3, 1'b0, 1'b0);
        run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0);
        run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
        run_instr(OP_JAL,    0, 0, 1'b0, 1'b0);
        run_instr(OP_JALR,   0, 0, 1'b0, 1'b0);
        run_instr(OP_ECALL,  0, 0, 1'b0, 1'b0);
        halt_cycles(10);
        reset_cycles(2, OP_ECALL);
        run_instr(OP_I,      1, 0, 1'b0, 1'b0);
        run_instr(OP_STORE,  0, 2, 1'b0, 1'b1);
        run_instr(OP_STORE,  2, 1, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 9);
            if (k < 9) begin
                op = known_ops[k];
            end else begin
                op = rnd7();
                while (is_known(op) || op == OP_ECALL) op = rnd7();
            end
            run_instr(op, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                      $urandom_range(0, 3), rbit(), 1'b0);
            if (n == 100) begin
                run_instr(OP_ECALL, 1, 0, 1'b0, 1'b0);
                halt_cycles(5);
                reset_cycles(2, OP_ECALL);
            end
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
